// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: condition codes, flag bit
// positions and FSM state encoding.
package branch_cond_unit_pkg;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_MI = 3'b101;
    localparam logic [2:0] COND_VS = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    // Matches the flag generator's {V,N,Z} packing.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StDone = 2'b10
    } bcu_state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition-code evaluator over {V,N,Z}; shared with predication logic.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       taken_o
);

    logic z, n, v;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];
    assign v = flags_i[FLAG_V];

    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            COND_AL: taken_o = 1'b1;
            COND_EQ: taken_o = z;
            COND_NE: taken_o = ~z;
            COND_LT: taken_o = n ^ v;
            COND_GE: taken_o = ~(n ^ v);
            COND_MI: taken_o = n;
            COND_VS: taken_o = v;
            COND_NV: taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Status-flag register plus conditional-branch resolver; stalls a branch until
// an in-flight flag-setting instruction writes the flags.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STALLW = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [2:0]        status_in,
    input  logic              status_we,
    input  logic              flag_pending,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [WIDTH-1:0]  br_target,
    output logic              res_valid,
    output logic              res_taken,
    output logic [WIDTH-1:0]  res_target,
    output logic [2:0]        flags,
    output logic [STALLW-1:0] stall_cycles
);

    bcu_state_e        state_q, state_d;
    logic [2:0]        flags_q, flags_d;
    logic [2:0]        cond_q, cond_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic              taken_q, taken_d;
    logic [WIDTH-1:0]  res_target_q, res_target_d;
    logic [STALLW-1:0] stall_q, stall_d;

    logic [2:0] eff_flags;
    logic [2:0] eval_cond;
    logic       eval_taken;
    logic       uncond;

    // Bypass lets a same-cycle flag write resolve the branch without stalling.
    assign eff_flags = status_we ? status_in : flags_q;
    assign eval_cond = (state_q == StWait) ? cond_q : br_cond;
    assign uncond    = (br_cond == COND_AL) || (br_cond == COND_NV);

    cond_eval u_cond_eval (
        .cond_i  (eval_cond),
        .flags_i (eff_flags),
        .taken_o (eval_taken)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            flags_q      <= 3'b000;
            cond_q       <= COND_AL;
            target_q     <= '0;
            taken_q      <= 1'b0;
            res_target_q <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            cond_q       <= cond_d;
            target_q     <= target_d;
            taken_q      <= taken_d;
            res_target_q <= res_target_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (br_valid) begin
                    if (flag_pending && !status_we && !uncond) state_d = StWait;
                    else                                       state_d = StDone;
                end
            end
            StWait:  if (status_we) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        flags_d      = status_we ? status_in : flags_q;
        cond_d       = cond_q;
        target_d     = target_q;
        taken_d      = taken_q;
        res_target_d = res_target_q;
        stall_d      = stall_q;

        if (state_q == StIdle && br_valid) begin
            cond_d   = br_cond;
            target_d = br_target;
        end
        if (state_d == StDone && state_q != StDone) begin
            taken_d      = eval_taken;
            res_target_d = (state_q == StIdle) ? br_target : target_q;
        end
        if (state_q == StWait && stall_q != {STALLW{1'b1}}) begin
            stall_d = stall_q + {{(STALLW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        br_ready     = resetn && (state_q == StIdle);
        res_valid    = (state_q == StDone);
        res_taken    = taken_q;
        res_target   = res_target_q;
        flags        = flags_q;
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit; a second STALLW=4 instance
// shares the stimulus to exercise counter saturation.
module tb_branch_cond_unit;

    logic        clock;
    logic        resetn;
    logic [2:0]  status_in;
    logic        status_we;
    logic        flag_pending;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;

    logic        br_ready, res_valid, res_taken;
    logic [15:0] res_target;
    logic [2:0]  flags;
    logic [15:0] stall_cycles;

    logic        s_br_ready, s_res_valid, s_res_taken;
    logic [15:0] s_res_target;
    logic [2:0]  s_flags;
    logic [3:0]  s_stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    branch_cond_unit #(.WIDTH(16), .STALLW(16)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .status_in    (status_in),
        .status_we    (status_we),
        .flag_pending (flag_pending),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_cond      (br_cond),
        .br_target    (br_target),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_target   (res_target),
        .flags        (flags),
        .stall_cycles (stall_cycles)
    );

    branch_cond_unit #(.WIDTH(16), .STALLW(4)) dut_small (
        .clock        (clock),
        .resetn       (resetn),
        .status_in    (status_in),
        .status_we    (status_we),
        .flag_pending (flag_pending),
        .br_valid     (br_valid),
        .br_ready     (s_br_ready),
        .br_cond      (br_cond),
        .br_target    (br_target),
        .res_valid    (s_res_valid),
        .res_taken    (s_res_taken),
        .res_target   (s_res_target),
        .flags        (s_flags),
        .stall_cycles (s_stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        status_in    = 3'b000;
        status_we    = 1'b0;
        flag_pending = 1'b0;
        br_valid     = 1'b0;
        br_cond      = 3'b000;
        br_target    = 16'h0000;

        tick();
        tick();
        check_eq("rst_br_ready", {31'b0, br_ready}, 32'd0);
        resetn = 1'b1;
        #1;
        check_eq("rst_br_ready_after", {31'b0, br_ready}, 32'd1);
        check_eq("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check_eq("rst_res_taken", {31'b0, res_taken}, 32'd0);
        check_eq("rst_res_target", {16'b0, res_target}, 32'd0);
        check_eq("rst_flags", {29'b0, flags}, 32'd0);
        check_eq("rst_stall", {16'b0, stall_cycles}, 32'd0);

        // Load Z, then EQ and NE without pending flags.
        status_we = 1'b1; status_in = 3'b001;
        tick();
        status_we = 1'b0;
        check_eq("load_flags_z", {29'b0, flags}, 32'h1);
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0040;
        tick();
        br_valid = 1'b0;
        check_eq("eq_valid", {31'b0, res_valid}, 32'd1);
        check_eq("eq_taken", {31'b0, res_taken}, 32'd1);
        check_eq("eq_target", {16'b0, res_target}, 32'h0040);
        check_eq("eq_done_ready", {31'b0, br_ready}, 32'd0);
        tick();
        check_eq("eq_back_idle_valid", {31'b0, res_valid}, 32'd0);
        check_eq("eq_back_idle_ready", {31'b0, br_ready}, 32'd1);
        br_valid = 1'b1; br_cond = 3'b010; br_target = 16'h0044;
        tick();
        br_valid = 1'b0;
        check_eq("ne_valid", {31'b0, res_valid}, 32'd1);
        check_eq("ne_taken", {31'b0, res_taken}, 32'd0);
        check_eq("ne_target", {16'b0, res_target}, 32'h0044);
        tick();

        // LT stalled by a pending flag write for 4 WAIT cycles.
        flag_pending = 1'b1;
        br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0100;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("lt_wait_ready", {31'b0, br_ready}, 32'd0);
            check_eq("lt_wait_valid", {31'b0, res_valid}, 32'd0);
            tick();
        end
        status_we = 1'b1; status_in = 3'b010; flag_pending = 1'b0;
        check_eq("lt_release_ready", {31'b0, br_ready}, 32'd0);
        tick();
        status_we = 1'b0;
        check_eq("lt_valid", {31'b0, res_valid}, 32'd1);
        check_eq("lt_taken", {31'b0, res_taken}, 32'd1);
        check_eq("lt_target", {16'b0, res_target}, 32'h0100);
        check_eq("lt_stall", {16'b0, stall_cycles}, 32'd4);
        check_eq("lt_flags", {29'b0, flags}, 32'h2);
        tick();

        // GE with simultaneous status write: bypass, no WAIT.
        flag_pending = 1'b1; status_we = 1'b1; status_in = 3'b110;
        br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0200;
        tick();
        br_valid = 1'b0; status_we = 1'b0;
        check_eq("ge_valid", {31'b0, res_valid}, 32'd1);
        check_eq("ge_taken", {31'b0, res_taken}, 32'd1);
        check_eq("ge_flags", {29'b0, flags}, 32'h6);
        check_eq("ge_stall", {16'b0, stall_cycles}, 32'd4);
        tick();

        // AL and NV never wait, even with flag_pending.
        br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h0300;
        tick();
        br_valid = 1'b0;
        check_eq("al_valid", {31'b0, res_valid}, 32'd1);
        check_eq("al_taken", {31'b0, res_taken}, 32'd1);
        tick();
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0304;
        tick();
        br_valid = 1'b0;
        check_eq("nv_valid", {31'b0, res_valid}, 32'd1);
        check_eq("nv_taken", {31'b0, res_taken}, 32'd0);
        check_eq("nv_target", {16'b0, res_target}, 32'h0304);
        // Flag write during DONE must not disturb the registered result.
        status_we = 1'b1; status_in = 3'b001;
        tick();
        status_we = 1'b0;
        check_eq("done_we_flags", {29'b0, flags}, 32'h1);
        check_eq("done_we_taken", {31'b0, res_taken}, 32'd0);
        check_eq("done_we_stall", {16'b0, stall_cycles}, 32'd4);

        // Reset mid-WAIT drops the request; status_we under reset is ignored.
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0400;
        tick();
        br_valid = 1'b0;
        check_eq("rw_in_wait", {31'b0, br_ready}, 32'd0);
        resetn = 1'b0; status_we = 1'b1; status_in = 3'b111;
        tick();
        check_eq("rw_ready_in_rst", {31'b0, br_ready}, 32'd0);
        check_eq("rw_flags", {29'b0, flags}, 32'd0);
        check_eq("rw_valid", {31'b0, res_valid}, 32'd0);
        check_eq("rw_target", {16'b0, res_target}, 32'd0);
        check_eq("rw_stall", {16'b0, stall_cycles}, 32'd0);
        resetn = 1'b1; status_in = 3'b100;
        #1;
        check_eq("rw_ready_after", {31'b0, br_ready}, 32'd1);
        tick();
        status_we = 1'b0;
        check_eq("rw_no_result", {31'b0, res_valid}, 32'd0);
        check_eq("rw_flags_after", {29'b0, flags}, 32'h4);
        check_eq("rw_ready_idle", {31'b0, br_ready}, 32'd1);

        // Long WAIT: the 4-bit counter saturates, the 16-bit one keeps counting.
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0500;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_small", {28'b0, s_stall_cycles}, 32'hF);
        check_eq("sat_wide", {16'b0, stall_cycles}, 32'd20);
        check_eq("sat_still_wait", {31'b0, res_valid}, 32'd0);
        status_we = 1'b1; status_in = 3'b001; flag_pending = 1'b0;
        tick();
        status_we = 1'b0;
        check_eq("sat_valid", {31'b0, res_valid}, 32'd1);
        check_eq("sat_taken", {31'b0, res_taken}, 32'd1);
        check_eq("sat_small_hold", {28'b0, s_stall_cycles}, 32'hF);
        check_eq("sat_wide_final", {16'b0, stall_cycles}, 32'd21);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the ALU status flags. Holds the architectural status register {V,N,Z} written by the ALU flag generator. Accepts conditional-branch requests from decode over a valid/ready handshake and stalls while a flag-setting instruction is still in flight. Returns a one-cycle taken/not-taken result with the branch target to the PC/fetch logic.

## Interface
- `WIDTH`, default 16: PC/target width.
- `STALLW`, default 16: stall counter width.

- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `status_in`  in  3  {overflow, negative, zero} from the ALU flag generator.
- `status_we`  in  1  `status_in` valid; commit to the flag register this cycle.
- `flag_pending`  in  1  a flag-setting instruction is issued but its `status_we` has not yet occurred.
- `br_valid`  in  1  branch request valid.
- `br_ready`  out  1  unit can accept a request.
- `br_cond`  in  3  condition code.
- `br_target`  in  WIDTH  target address.
- `res_valid`  out  1  one-cycle result strobe.
- `res_taken`  out  1  condition true.
- `res_target`  out  WIDTH  captured target; valid with `res_valid`.
- `flags`  out  3  current flag register {V,N,Z}.
- `stall_cycles`  out  STALLW  saturating count of cycles spent in WAIT.

## Operation
- Flag register `flags`:
  - Loads `status_in` on every cycle with `status_we=1`, in any state.
  - Reset value 3'b000.
- Condition codes (effective flags F):
  - 000 AL: always.
  - 001 EQ: Z.
  - 010 NE: !Z.
  - 011 LT: N^V.
  - 100 GE: !(N^V).
  - 101 MI: N.
  - 110 VS: V.
  - 111 NV: never.
- Effective flags F:
  - `status_in` when `status_we=1` in the evaluating cycle (bypass).
  - Otherwise `flags`.
- FSM states IDLE, WAIT, DONE; reset state IDLE.
  - IDLE: `br_ready=1`. On `br_valid`, capture `br_cond` and `br_target`.
    - Go to WAIT if `flag_pending=1`, `status_we=0`, and cond is not AL/NV.
    - Otherwise evaluate now, register `res_taken`, and go to DONE.
  - WAIT: `br_ready=0`. `stall_cycles` increments each cycle, saturating at all-ones.
    - On `status_we=1`, evaluate with bypassed `status_in` and go to DONE.
    - `flag_pending` is ignored in WAIT. Only `status_we` releases the stall.
  - DONE: `res_valid=1`, `br_ready=0`; go to IDLE unconditionally.
- AL/NV never wait, regardless of `flag_pending`.
- No backpressure on the result: the consumer must take it in the `res_valid` cycle.
- `res_taken`/`res_target` hold their last values outside DONE. They are meaningful only with `res_valid`.

## Timing
- Reset values: `br_ready=0` during the reset cycle and `br_ready=1` after it; `res_valid=0`, `res_taken=0`, `res_target=0`, `flags=0`, `stall_cycles=0`.
- No-stall latency: request accepted at edge N → `res_valid=1` in cycle N+1.
- Stall latency: `status_we` in cycle M while in WAIT → `res_valid` in cycle M+1.
- Throughput: one branch per 2 cycles minimum.
- Simultaneous `br_valid` and `status_we` in IDLE:
  - The bypass applies and there is no WAIT, even if `flag_pending=1`.
  - `flags` also updates that edge.
- `status_we` during DONE updates `flags` only; the registered result is unaffected.
- `resetn=0` at any edge, including mid-WAIT or in DONE:
  - FSM returns to IDLE and the captured request is dropped.
  - No `res_valid` is produced for it.
  - All outputs and the counter return to their reset values.

## Structure
- Shared package:
  - Condition-code constants COND_AL…COND_NV.
  - Flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_V=2, matching the flag generator's packing {V,N,Z}.
  - FSM state encoding.
- Sub-module: `cond_eval`, purely combinational (cond, flags → taken). It is reused by any later predicated-execution logic.

## Test plan
- Flags loaded 3'b001 (Z) with `flag_pending=0`; issue EQ, target 16'h0040 → next cycle `res_valid=1`, `res_taken=1`, `res_target=16'h0040`. Repeat with NE → `res_taken=0`.
- `flag_pending=1`; issue LT, target 16'h0100; hold 3 cycles; then `status_we=1`, `status_in=3'b010` (N, !V):
  - `br_ready=0` for the stall.
  - `res_valid`/`res_taken=1` the cycle after `status_we`.
  - `stall_cycles=4`.
- Same cycle: `br_valid` (GE), `flag_pending=1`, `status_we=1`, `status_in=3'b110`:
  - No WAIT.
  - `res_taken=1` next cycle (N^V=0).
  - `flags=3'b110`.
- AL and NV with `flag_pending=1` → no stall; `res_taken` 1 and 0 respectively.
- Enter WAIT, assert `resetn=0` one cycle, then `status_we` → no `res_valid`, `flags=0` after reset, `br_ready=1` after reset; `status_we` during reset is ignored.
- Force `stall_cycles` near all-ones via a long WAIT (small `STALLW=4`) → counter saturates at 4'hF, no wrap.
